// File: rtl/uart_apb_fifo_if.sv
// APB slave bus bundle for uart_apb_fifo.
interface uart_apb_fifo_if;
  logic        PSEL;
  logic        PENABLE;
  logic [1:0]  PADDR;
  logic        PWRITE;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY;

  modport master (output PSEL, PENABLE, PADDR, PWRITE, PWDATA, input PRDATA, PREADY);
  modport slave  (input PSEL, PENABLE, PADDR, PWRITE, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/uart_apb_fifo.sv
// APB UART with TX/RX FIFOs, 16x oversampled baud generator, parity and interrupt.
// Optional macro UART_LOOPBACK_EN implements CTRL bit7 (internal TX->RX loopback).
module uart_apb_fifo #(
  parameter int          DATA_W      = 8,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          DIV_W       = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
  input  logic           PCLK,
  input  logic           PRESETN,
  uart_apb_fifo_if.slave apb,
  input  logic           RX,
  output logic           TX,
  output logic           TXRDY,
  output logic           RXRDY,
  output logic           IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [2:0]  LAST_BIT = 3'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic access, rd, wr;
  logic data_wr, data_rd, stat_rd, baud_wr, ctrl_wr;
  assign access  = apb.PSEL & apb.PENABLE;
  assign rd      = access & ~apb.PWRITE;
  assign wr      = access & apb.PWRITE;
  assign data_wr = wr & (apb.PADDR == 2'd0);
  assign data_rd = rd & (apb.PADDR == 2'd0);
  assign stat_rd = rd & (apb.PADDR == 2'd1);
  assign baud_wr = wr & (apb.PADDR == 2'd2);
  assign ctrl_wr = wr & (apb.PADDR == 2'd3);

  logic [DIV_W-1:0] baud_reg, baud_cnt_reg;
  logic [7:0]       ctrl_reg;
  logic             baud_tick;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      baud_reg <= DEFAULT_DIV[DIV_W-1:0];
      ctrl_reg <= 8'h0C;
    end else begin
      if (baud_wr) baud_reg <= apb.PWDATA[DIV_W-1:0];
`ifdef UART_LOOPBACK_EN
      if (ctrl_wr) ctrl_reg <= apb.PWDATA[7:0];
`else
      if (ctrl_wr) ctrl_reg <= {1'b0, apb.PWDATA[6:0]};
`endif
    end
  end

  // Counter spans 0..DIV so a tick fires every DIV+1 cycles.
  assign baud_tick = (baud_cnt_reg == baud_reg);
  always_ff @(posedge PCLK) begin
    if (!PRESETN || baud_wr || baud_tick) baud_cnt_reg <= '0;
    else                                  baud_cnt_reg <= baud_cnt_reg + DIV_W'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wp_reg, tx_rp_reg;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  assign tx_empty = (tx_wp_reg == tx_rp_reg);
  assign tx_full  = (tx_wp_reg[AW] != tx_rp_reg[AW]) && (tx_wp_reg[AW-1:0] == tx_rp_reg[AW-1:0]);
  assign tx_push  = data_wr & ~tx_full;

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp_reg[AW-1:0]] <= apb.PWDATA[DATA_W-1:0];
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      tx_wp_reg <= '0;
      tx_rp_reg <= '0;
    end else begin
      if (tx_push) tx_wp_reg <= tx_wp_reg + PTR_ONE;
      if (tx_pop)  tx_rp_reg <= tx_rp_reg + PTR_ONE;
    end
  end

  // ---------------- Transmitter ----------------
  state_t            tx_state_reg;
  logic [3:0]        tx_cnt_reg;
  logic [2:0]        tx_bit_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              tx_par_reg, tx_reg, tx_idle;

  // Frames only start on a tick so every bit is exactly 16 ticks long.
  assign tx_pop = baud_tick & ctrl_reg[2] & ~tx_empty &
                  ((tx_state_reg == S_IDLE) || (tx_state_reg == S_STOP && tx_cnt_reg == 4'd15));
  assign tx_idle = tx_empty & (tx_state_reg == S_IDLE);

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else if (tx_pop) begin
      tx_state_reg <= S_START;
      tx_cnt_reg   <= '0;
      tx_shift_reg <= tx_mem[tx_rp_reg[AW-1:0]];
      tx_par_reg   <= ^tx_mem[tx_rp_reg[AW-1:0]];
      tx_reg       <= 1'b0;
    end else if (baud_tick && tx_state_reg != S_IDLE) begin
      tx_cnt_reg <= tx_cnt_reg + 4'd1;
      if (tx_cnt_reg == 4'd15) begin
        case (tx_state_reg)
          S_START: begin
            tx_state_reg <= S_DATA;
            tx_bit_reg   <= '0;
            tx_reg       <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
          end
          S_DATA: begin
            if (tx_bit_reg == LAST_BIT) begin
              tx_state_reg <= ctrl_reg[0] ? S_PARITY : S_STOP;
              tx_reg       <= ctrl_reg[0] ? (tx_par_reg ^ ctrl_reg[1]) : 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_reg       <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
            end
          end
          S_PARITY: begin
            tx_state_reg <= S_STOP;
            tx_reg       <= 1'b1;
          end
          S_STOP:  tx_state_reg <= S_IDLE;
          default: tx_state_reg <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- Receiver ----------------
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  assign rx_in = ctrl_reg[7] ? tx_reg : RX;
  assign TX    = ctrl_reg[7] | tx_reg;
`else
  assign rx_in = RX;
  assign TX    = tx_reg;
`endif

  logic rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_prev_reg  <= 1'b1;
    end else begin
      rx_sync1_reg <= rx_in;
      rx_sync2_reg <= rx_sync1_reg;
      rx_prev_reg  <= rx_sync2_reg;
    end
  end

  state_t            rx_state_reg;
  logic [3:0]        rx_cnt_reg;
  logic [2:0]        rx_bit_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic              rx_push_reg, perr_evt_reg, ferr_evt_reg;

  // Counter restarts at mid-start so later samples land at count 15 = bit centre.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      rx_state_reg <= S_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_push_reg  <= 1'b0;
      perr_evt_reg <= 1'b0;
      ferr_evt_reg <= 1'b0;
    end else begin
      rx_push_reg  <= 1'b0;
      perr_evt_reg <= 1'b0;
      ferr_evt_reg <= 1'b0;
      case (rx_state_reg)
        S_IDLE: begin
          if (ctrl_reg[3] && rx_prev_reg && !rx_sync2_reg) begin
            rx_state_reg <= S_START;
            rx_cnt_reg   <= '0;
          end
        end
        S_START: begin
          if (baud_tick) begin
            if (rx_cnt_reg == 4'd7) begin
              rx_cnt_reg   <= '0;
              rx_bit_reg   <= '0;
              rx_state_reg <= rx_sync2_reg ? S_IDLE : S_DATA;
            end else begin
              rx_cnt_reg <= rx_cnt_reg + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            rx_cnt_reg <= rx_cnt_reg + 4'd1;
            if (rx_cnt_reg == 4'd15) begin
              rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[DATA_W-1:1]};
              rx_bit_reg   <= rx_bit_reg + 3'd1;
              if (rx_bit_reg == LAST_BIT) rx_state_reg <= ctrl_reg[0] ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            rx_cnt_reg <= rx_cnt_reg + 4'd1;
            if (rx_cnt_reg == 4'd15) begin
              perr_evt_reg <= rx_sync2_reg ^ (^rx_shift_reg) ^ ctrl_reg[1];
              rx_state_reg <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            rx_cnt_reg <= rx_cnt_reg + 4'd1;
            if (rx_cnt_reg == 4'd15) begin
              rx_push_reg  <= rx_sync2_reg;
              ferr_evt_reg <= ~rx_sync2_reg;
              rx_state_reg <= S_IDLE;
            end
          end
        end
        default: rx_state_reg <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       rx_wp_reg, rx_rp_reg;
  logic              rx_empty, rx_full, rx_pop, rx_push_ok, ovf_rx_evt;
  assign rx_empty   = (rx_wp_reg == rx_rp_reg);
  assign rx_full    = (rx_wp_reg[AW] != rx_rp_reg[AW]) && (rx_wp_reg[AW-1:0] == rx_rp_reg[AW-1:0]);
  assign rx_pop     = data_rd & ~rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign rx_push_ok = rx_push_reg & (~rx_full | rx_pop);
  assign ovf_rx_evt = rx_push_reg & rx_full & ~rx_pop;

  always_ff @(posedge PCLK) begin
    if (rx_push_ok) rx_mem[rx_wp_reg[AW-1:0]] <= rx_shift_reg;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      rx_wp_reg <= '0;
      rx_rp_reg <= '0;
    end else begin
      if (rx_push_ok) rx_wp_reg <= rx_wp_reg + PTR_ONE;
      if (rx_pop)     rx_rp_reg <= rx_rp_reg + PTR_ONE;
    end
  end

  // ---------------- Flags, IRQ, read mux ----------------
  logic ovf_rx_reg, perr_reg, ferr_reg, ovf_tx_reg, irq_reg;
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      ovf_rx_reg <= 1'b0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      ovf_tx_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      ovf_rx_reg <= ovf_rx_evt   | (ovf_rx_reg & ~stat_rd);
      perr_reg   <= perr_evt_reg | (perr_reg & ~stat_rd);
      ferr_reg   <= ferr_evt_reg | (ferr_reg & ~stat_rd);
      ovf_tx_reg <= (data_wr & tx_full) | (ovf_tx_reg & ~stat_rd);
      irq_reg    <= (ctrl_reg[4] & ~rx_empty) | (ctrl_reg[5] & tx_idle) |
                    (ctrl_reg[6] & (ovf_rx_reg | perr_reg | ferr_reg | ovf_tx_reg));
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (rd) begin
      case (apb.PADDR)
        2'd0: if (!rx_empty) apb.PRDATA = 16'(rx_mem[rx_rp_reg[AW-1:0]]);
        2'd1: apb.PRDATA = {9'd0, ovf_tx_reg, tx_idle, ferr_reg, perr_reg, ovf_rx_reg, ~rx_empty, ~tx_full};
        2'd2: apb.PRDATA = 16'(baud_reg);
        default: apb.PRDATA = {8'd0, ctrl_reg};
      endcase
    end
  end

  assign apb.PREADY = 1'b1;
  assign TXRDY      = ~tx_full;
  assign RXRDY      = ~rx_empty;
  assign IRQ        = irq_reg;
endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed self-checking bench for uart_apb_fifo (APB regs, TX framing, FIFOs, RX errors).
`timescale 1ns/1ps
module tb_uart_apb_fifo;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx_drive = 1'b1;
  logic loop_tb = 1'b0;
  logic rx_pin, tx, txrdy, rxrdy, irq;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  uart_apb_fifo_if apb();
  assign rx_pin = loop_tb ? tx : rx_drive;

  uart_apb_fifo dut (
    .PCLK(clk), .PRESETN(rstn), .apb(apb),
    .RX(rx_pin), .TX(tx), .TXRDY(txrdy), .RXRDY(rxrdy), .IRQ(irq)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=0x%04h", tag, got);
    end else begin
      $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = a; apb.PWRITE = 1'b1; apb.PWDATA = d;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = a; apb.PWRITE = 1'b0;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    #1 d = apb.PRDATA;
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] d;
    apb_read(a, d);
    check_eq(tag, d, exp);
  endtask

  // One frame on the RX pin at 32 PCLK per bit (BAUD=1), then two idle bit times.
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit, input logic stop_bit);
    @(negedge clk);
    rx_drive = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = d[i];
      repeat (32) @(negedge clk);
    end
    if (par_en) begin
      rx_drive = par_bit;
      repeat (32) @(negedge clk);
    end
    rx_drive = stop_bit;
    repeat (32) @(negedge clk);
    rx_drive = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_bits [10];
    int          cnt;
    logic        seen;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = 2'd0; apb.PWRITE = 1'b0; apb.PWDATA = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx", {15'd0, tx}, 16'd1);
    check_eq("rst_irq", {15'd0, irq}, 16'd0);
    check_eq("rst_txrdy", {15'd0, txrdy}, 16'd1);
    check_eq("rst_rxrdy", {15'd0, rxrdy}, 16'd0);
    check_eq("rst_prdata", apb.PRDATA, 16'h0000);
    rstn = 1'b1;
    rd_check("rst_status", 2'd1, 16'h0021);
    rd_check("rst_baud",   2'd2, 16'h001A);
    rd_check("rst_ctrl",   2'd3, 16'h000C);

    // TX frame 0xA5 with even parity at 64 PCLK per bit
    apb_write(2'd2, 16'd3);
    apb_write(2'd3, 16'h000D);
    rd_check("ctrl_rb", 2'd3, 16'h000D);
    apb_write(2'd0, 16'h00A5);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 200) begin @(negedge clk); cnt++; end
    check_eq("tx_start_seen", {15'd0, tx == 1'b0}, 16'd1);
    cnt = 0;
    while (tx === 1'b0 && cnt < 200) begin @(negedge clk); cnt++; end
    check_eq("tx_start_len", 16'(cnt), 16'd64);
    exp_bits = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    repeat (32) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("tx_bit%0d", i), {15'd0, tx}, 16'(exp_bits[i]));
      repeat (64) @(negedge clk);
    end
    rd_check("tx_idle_status", 2'd1, 16'h0021);

    // TX FIFO fill with TX disabled; then loop pin-to-pin to see what actually gets sent
    apb_write(2'd2, 16'd0);
    apb_write(2'd3, 16'h0008);
    for (int i = 0; i < 16; i++) begin
      apb_write(2'd0, 16'h0010 + 16'(i));
      if (i == 14) check_eq("txrdy_15", {15'd0, txrdy}, 16'd1);
    end
    check_eq("txrdy_16", {15'd0, txrdy}, 16'd0);
    apb_write(2'd0, 16'h00EE);
    rd_check("ovf_tx_status", 2'd1, 16'h0040);
    rd_check("ovf_tx_cleared", 2'd1, 16'h0000);
    loop_tb = 1'b1;
    apb_write(2'd3, 16'h000C);
    repeat (3000) @(negedge clk);
    rd_check("fill_rx_status", 2'd1, 16'h0023);
    for (int i = 0; i < 16; i++) rd_check($sformatf("fill_rx%0d", i), 2'd0, 16'h0010 + 16'(i));
    rd_check("fill_rx_empty", 2'd1, 16'h0021);
    loop_tb = 1'b0;

    // RX framing error then a good frame, with IE_ERR
    apb_write(2'd2, 16'd1);
    apb_write(2'd3, 16'h004C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("ferr_rxrdy", {15'd0, rxrdy}, 16'd0);
    check_eq("ferr_irq", {15'd0, irq}, 16'd1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check_eq("good_rxrdy", {15'd0, rxrdy}, 16'd1);
    rd_check("good_data", 2'd0, 16'h003C);
    rd_check("ferr_status", 2'd1, 16'h0031);
    repeat (2) @(negedge clk);
    check_eq("ferr_irq_clr", {15'd0, irq}, 16'd0);
    rd_check("ferr_cleared", 2'd1, 16'h0021);
    rd_check("empty_data", 2'd0, 16'h0000);

    // Odd parity: wrong parity sets PERR but keeps the character
    apb_write(2'd3, 16'h000F);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    rd_check("perr_status", 2'd1, 16'h002B);
    rd_check("perr_data", 2'd0, 16'h003C);
    send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
    rd_check("par_ok_status", 2'd1, 16'h0023);
    rd_check("par_ok_data", 2'd0, 16'h00C1);

    // RX overflow: 17 frames, no reads
    apb_write(2'd3, 16'h000C);
    for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
    rd_check("ovf_rx_status", 2'd1, 16'h0027);
    for (int i = 0; i < 16; i++) rd_check($sformatf("ovf_rx%0d", i), 2'd0, 16'h0040 + 16'(i));
    rd_check("ovf_rx_drained", 2'd1, 16'h0021);

`ifdef UART_LOOPBACK_EN
    apb_write(2'd3, 16'h008C);
    rd_check("loop_ctrl", 2'd3, 16'h008C);
    rx_drive = 1'b0;
    apb_write(2'd0, 16'h005A);
    seen = 1'b0;
    cnt = 0;
    while (!rxrdy && cnt < 1000) begin
      @(negedge clk);
      if (tx !== 1'b1) seen = 1'b1;
      cnt++;
    end
    check_eq("loop_tx_quiet", {15'd0, seen}, 16'd0);
    check_eq("loop_rxrdy", {15'd0, rxrdy}, 16'd1);
    rd_check("loop_data", 2'd0, 16'h005A);
    rx_drive = 1'b1;
    apb_write(2'd3, 16'h000C);
`else
    apb_write(2'd3, 16'h008C);
    rd_check("noloop_ctrl", 2'd3, 16'h000C);
    apb_write(2'd3, 16'h000C);
`endif

    // Reset in the middle of a frame
    apb_write(2'd0, 16'h0000);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 100) begin @(negedge clk); cnt++; end
    check_eq("mid_start_seen", {15'd0, tx == 1'b0}, 16'd1);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_tx", {15'd0, tx}, 16'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rd_check("mid_rst_status", 2'd1, 16'h0021);
    rd_check("mid_rst_baud", 2'd2, 16'h001A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_apb_fifo.md
Name: uart_apb_fifo

Overview:
Parametrised APB UART, the successor to the single-character APB UART core.
- Adds TX and RX FIFOs, a programmable 16x-oversampled baud divisor, and a selectable character length.
- Adds even/odd parity, sticky overflow/parity/framing flags and a maskable interrupt.
- Sits on the peripheral APB bus as a zero-wait slave; drives the serial TX/RX pins directly.

Parameters:
- DATA_W, 8, character bits per frame (5..8); unused high bits of PWDATA are ignored and PRDATA reads them as 0.
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of 2, minimum 2.
- DIV_W, 16, baud divisor register width (at most 16).
- DEFAULT_DIV, 16'd26, reset value of BAUD.

Ports:
- PCLK  in  1  system clock
- PRESETN  in  1  synchronous active-low reset, sampled on PCLK rising edge
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PADDR  in  2  register address
- PWRITE  in  1  1 = write
- PWDATA  in  16  write data
- PRDATA  out  16  read data
- PREADY  out  1  always 1 (zero wait states)
- RX  in  1  serial input, asynchronous
- TX  out  1  serial output, idle high
- TXRDY  out  1  TX FIFO not full
- RXRDY  out  1  RX FIFO not empty
- IRQ  out  1  interrupt, level, active-high

Behaviour:
- Clock and reset: one clock, PCLK. Reset is synchronous and active-low on PRESETN.
- Reset values:
  - TX=1, PRDATA=0, PREADY=1, TXRDY=1, RXRDY=0, IRQ=0.
  - Both FIFOs empty, all sticky flags 0, BAUD=DEFAULT_DIV, CTRL=0x000C.
  - Reset asserted mid-frame aborts the frame: TX returns high on the next edge, RX returns to IDLE.
- APB protocol:
  - A write or read occurs on the cycle where PSEL&PENABLE=1.
  - PRDATA is valid during the access phase and is 0 otherwise.
- Register map:
  - 0 DATA. Write pushes PWDATA[DATA_W-1:0] into the TX FIFO; if the FIFO is full the write is dropped and OVF_TX is set. Read returns the RX FIFO head and pops it in the same access; if empty it returns 0 and does not pop.
  - 1 STATUS (read only): bit0 TXRDY, bit1 RXRDY, bit2 OVF_RX, bit3 PERR, bit4 FERR, bit5 TX_IDLE (TX FIFO empty and shifter idle), bit6 OVF_TX. Bits 2,3,4,6 clear on a STATUS read. A flag event in the same cycle as the clearing read wins, so the flag stays set.
  - 2 BAUD: divisor DIV in bits [DIV_W-1:0], read/write.
  - 3 CTRL, read/write: bit0 PAR_EN, bit1 PAR_ODD, bit2 TX_EN, bit3 RX_EN, bit4 IE_RX, bit5 IE_TXE, bit6 IE_ERR, bit7 LOOP (see optional feature).
- Baud generator:
  - Counter runs 0..DIV and emits a 1-cycle tick on wrap, i.e. one tick per DIV+1 PCLK cycles = 16x bit rate.
  - Writing BAUD reloads the counter to 0.
  - DIV=0 gives a tick every cycle.
- Transmitter:
  - States IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when TX_EN=1 and the TX FIFO is not empty; the FIFO pops on that transition.
  - Each state lasts 16 ticks.
  - DATA shifts DATA_W bits, LSB first.
  - PARITY is skipped when PAR_EN=0. Parity bit = XOR of data bits, inverted when PAR_ODD=1.
  - Exactly one stop bit; then IDLE, or directly START if the FIFO is not empty (back-to-back frames, no idle gap).
  - Clearing TX_EN finishes the current frame, then holds in IDLE.
- Receiver:
  - RX passes through a 2-flop synchroniser reset to 1.
  - States IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised falling edge when RX_EN=1.
  - START re-samples at tick 7: if the line is high it is a glitch and returns to IDLE; otherwise every later bit is sampled at its tick-15 midpoint-aligned count.
  - Parity mismatch sets PERR.
  - A stop bit of 0 sets FERR and the character is discarded.
  - A good character is pushed to the RX FIFO at the end of STOP. If the FIFO is full, set OVF_RX and drop the new character; FIFO contents are preserved.
  - A simultaneous push and APB pop on a full FIFO is legal: no overflow.
- FIFOs:
  - Synchronous, with registered read/write pointers of width log2(FIFO_DEPTH)+1; full/empty come from the pointer MSB.
  - Push and pop in the same cycle keep the count unchanged.
- IRQ:
  - IRQ = (IE_RX & RXRDY) | (IE_TXE & TX_IDLE) | (IE_ERR & (OVF_RX|PERR|FERR|OVF_TX)).
  - Registered: one cycle latency.

Optional Feature:
UART_LOOPBACK_EN
- Defined: CTRL bit7 LOOP is implemented. When LOOP=1, the receiver input is the internal TX serial stream (before the pin), the TX pin is held at 1, and the RX pin is ignored.
- Undefined: CTRL bit7 reads 0, writes to it are ignored, and no loopback mux is present.

Test Plan:
- Reset: hold PRESETN=0 for 3 cycles -> TX=1, STATUS=0x0021, BAUD=0x001A, CTRL=0x000C, IRQ=0.
- TX frame: BAUD=3, CTRL=0x000D, write DATA=0xA5 -> TX is low for 64 PCLK, then bits 1,0,1,0,0,1,0,1 at 64 cycles each, then parity 0, then stop 1; TX_IDLE=1 afterwards.
- TX FIFO fill: write 17 bytes with FIFO_DEPTH=16 and TX_EN=0 -> TXRDY=0 after the 16th write, STATUS bit6=1, and the 17th byte is never transmitted.
- RX with errors: drive a frame 0x3C with stop=0 -> FERR=1, RXRDY=0; then a good 0x3C -> RXRDY=1, DATA read returns 0x003C, and the next STATUS read clears FERR.
- RX overflow: 17 good frames with no reads -> OVF_RX=1, and 16 reads return the first 16 bytes in order.
- Loopback (UART_LOOPBACK_EN): CTRL=0x008C, write 0x5A -> the TX pin stays 1, RXRDY=1 after about 160*(DIV+1) cycles, and a DATA read returns 0x005A.
